axi_lite_read_slave: RTL and testbench

AXI4-Lite read-side responder: accepts read addresses on the AR channel and returns data plus response on the R channel from a local bank of 32-bit registers. It is the read-direction counterpart of the write-address master/slave pair and sits at the slave end of the bus, next to the write path. The local side loads the register bank through a simple write port and reads completed and errored transaction counts.

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_lite_read_slave_if.sv | 25 ++
 rtl/axi_lite_read_slave_reg_bank.sv | 38 +++
 rtl/axi_lite_read_slave.sv | 119 +++++++++++
 tb/tb_axi_lite_read_slave.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions used by both the read and the write path.
//   RESP_OKAY / RESP_SLVERR : RRESP/BRESP encodings
//   CNT_W                   : width of the transaction counters
//   axi_rd_state_e          : two-state responder FSM encoding
//   resp_for()              : maps an error flag to the response code
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CNT_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } axi_rd_state_e;

    function automatic logic [1:0] resp_for(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_read_slave_if.sv
// AXI4-Lite read channels (AR + R) bundled for the read responder.
//   master modport : drives ARVALID/ARADDR/ARPROT/RREADY
//   slave modport  : drives ARREADY/RVALID/RDATA/RRESP
interface axi_lite_read_slave_if #(
    parameter int ADDR_W = 32
);
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic              RVALID;
    logic              RREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;

    modport master (
        output ARVALID, ARADDR, ARPROT, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  ARVALID, ARADDR, ARPROT, RREADY,
        output ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_read_slave_reg_bank.sv
// read_reg_bank: NUM_REGS x 32-bit register array.
//   clk, rst       : clock, synchronous active-high clear of all registers
//   we/widx/wdata  : local write port; out-of-range indices are dropped
//   ridx           : full word index taken from the bus address
//   rdata          : combinational read (0 when ridx is out of range)
//   in_range       : ridx addresses an existing register
module read_reg_bank #(
    parameter int NUM_REGS = 16,
    parameter int RIDX_W   = 30
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] widx,
    input  logic [31:0]                 wdata,
    input  logic [RIDX_W-1:0]           ridx,
    output logic [31:0]                 rdata,
    output logic                        in_range
);
    localparam int WIDX_W = $clog2(NUM_REGS);
    localparam logic [RIDX_W-1:0] NUM_REGS_R = RIDX_W'(NUM_REGS);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (int'(widx) < NUM_REGS)) begin
            regs[widx] <= wdata;
        end
    end

    assign in_range = (ridx < NUM_REGS_R);
    // Low index bits are only trusted once the full index is known to be in range.
    assign rdata    = in_range ? regs[ridx[WIDX_W-1:0]] : '0;
endmodule

// File: rtl/axi_lite_read_slave.sv
// axi_lite_read_slave: AXI4-Lite read responder backed by a local register bank.
//   ACLK, ARESETn          : clock, synchronous active-high reset
//   s_axi (slave modport)  : AR and R channels
//   reg_we/widx/wdata      : local register load port
//   rd_count / err_count   : completed R handshakes / those answered with SLVERR
// All bus outputs are registered; ARREADY and RVALID never depend on the
// same-cycle ARVALID/RREADY.
module axi_lite_read_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int PRIV_BASE = 12
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    axi_lite_read_slave_if.slave        s_axi,
    input  logic                        reg_we,
    input  logic [$clog2(NUM_REGS)-1:0] reg_widx,
    input  logic [31:0]                 reg_wdata,
    output logic [CNT_W-1:0]            rd_count,
    output logic [CNT_W-1:0]            err_count
);
    localparam int RIDX_W = ADDR_W - 2;
    localparam logic [RIDX_W-1:0] PRIV_IDX = RIDX_W'(PRIV_BASE);

    localparam logic [0:0] IDLE = ST_IDLE;
    localparam logic [0:0] DATA = ST_DATA;

    logic [0:0]       state;
    logic             arready_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] err_cnt;

    logic [RIDX_W-1:0] ar_idx;
    logic [31:0]       bank_rdata;
    logic              bank_in_range;
    logic              priv_viol;
    logic              dec_err;
    logic              ar_hs;
    logic              r_hs;
    logic              unused_bits;

    assign ar_idx      = s_axi.ARADDR[ADDR_W-1:2];
    assign unused_bits = ^{s_axi.ARADDR[1:0], s_axi.ARPROT[2:1]};

    read_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .RIDX_W   (RIDX_W)
    ) u_bank (
        .clk      (ACLK),
        .rst      (ARESETn),
        .we       (reg_we),
        .widx     (reg_widx),
        .wdata    (reg_wdata),
        .ridx     (ar_idx),
        .rdata    (bank_rdata),
        .in_range (bank_in_range)
    );

    assign priv_viol = (ar_idx >= PRIV_IDX) && !s_axi.ARPROT[0];
    assign dec_err   = !bank_in_range || priv_viol;

    assign ar_hs = (state == IDLE) && s_axi.ARVALID && arready_q;
    assign r_hs  = (state == DATA) && rvalid_q && s_axi.RREADY;

    // The bank read is combinational, so capturing it here takes the value
    // from before any reg_we landing on the same edge. Once in DATA the
    // captured word is independent of later bank writes.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            state     <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rd_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    arready_q <= !ar_hs;
                    if (ar_hs) begin
                        state    <= DATA;
                        rvalid_q <= 1'b1;
                        rdata_q  <= dec_err ? 32'h0 : bank_rdata;
                        rresp_q  <= resp_for(dec_err);
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        state     <= IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_cnt    <= rd_cnt + 1'b1;
                        if (rresp_q == RESP_SLVERR) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
    assign rd_count      = rd_cnt;
    assign err_count     = err_cnt;
endmodule

// File: tb/tb_axi_lite_read_slave.sv
// Scoreboard bench for axi_lite_read_slave: a predictor turns every AR
// handshake into an expected (RDATA, RRESP) from a plain register-array model;
// a monitor pops on every R handshake and tracks counters and channel rules.
module tb_axi_lite_read_slave;
    import axi_lite_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic        ACLK;
    logic        ARESETn;
    logic        reg_we;
    logic [3:0]  reg_widx;
    logic [31:0] reg_wdata;
    logic [15:0] rd_count;
    logic [15:0] err_count;

    axi_lite_read_slave_if #(.ADDR_W(32)) bus ();

    axi_lite_read_slave #(
        .ADDR_W    (32),
        .NUM_REGS  (16),
        .PRIV_BASE (12)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .s_axi     (bus.slave),
        .reg_we    (reg_we),
        .reg_widx  (reg_widx),
        .reg_wdata (reg_wdata),
        .rd_count  (rd_count),
        .err_count (err_count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb_q[$];
    logic [31:0] model_regs [16];
    logic [15:0] exp_rd  = '0;
    logic [15:0] exp_err = '0;
    bit          rnd_en  = 1'b0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, req);
        end
    endfunction

    function automatic void fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not seen within budget", nm);
    endfunction

    // Reference decode: word index, range check, then privilege check.
    function automatic exp_t predict(input logic [31:0] addr, input logic [2:0] prot);
        exp_t        e;
        int unsigned idx;
        idx = addr >> 2;
        if (idx >= 16 || (idx >= 12 && prot[0] == 1'b0)) begin
            e.data = 32'h0;
            e.resp = 2'b10;
        end else begin
            e.data = model_regs[idx];
            e.resp = 2'b00;
        end
        return e;
    endfunction

    // Predictor: looks at what the next rising edge will see.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
            sb_q.delete();
        end else begin
            if (bus.ARVALID && bus.ARREADY) sb_q.push_back(predict(bus.ARADDR, bus.ARPROT));
            if (reg_we) model_regs[reg_widx] = reg_wdata;
        end
    end

    // Monitor
    bit          seen_rst = 1'b0;
    bit          prev_rst = 1'b0, prev2_rst = 1'b0;
    bit          prev_arhs = 1'b0, prev_rhs = 1'b0;
    bit          prev_rvalid = 1'b0, prev_rready = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic [1:0]  prev_rresp = '0;

    always @(negedge ACLK) begin
        bit   cur_arhs, cur_rhs;
        exp_t e;
        if (seen_rst) begin
            check("rd_count", 32'(rd_count), 32'(exp_rd));
            check("err_count", 32'(err_count), 32'(exp_err));
            if (bus.ARREADY && bus.RVALID) check("arready_rvalid_exclusive", 32'(bus.ARREADY), 32'h0);
            if (prev_rst) begin
                check("reset_rvalid", 32'(bus.RVALID), 32'h0);
                check("reset_rdata", bus.RDATA, 32'h0);
                check("reset_rresp", 32'(bus.RRESP), 32'h0);
            end else begin
                if (prev2_rst) check("arready_after_reset", 32'(bus.ARREADY), 32'h1);
                if (prev_arhs) check("rvalid_latency", 32'(bus.RVALID), 32'h1);
                if (prev_rhs) begin
                    check("rvalid_after_hs", 32'(bus.RVALID), 32'h0);
                    check("arready_after_hs", 32'(bus.ARREADY), 32'h1);
                end
                if (prev_rvalid && !prev_rready) begin
                    check("hold_rvalid", 32'(bus.RVALID), 32'h1);
                    check("hold_rdata", bus.RDATA, prev_rdata);
                    check("hold_rresp", 32'(bus.RRESP), 32'(prev_rresp));
                end
            end
        end
        cur_arhs = !ARESETn && bus.ARVALID && bus.ARREADY;
        cur_rhs  = !ARESETn && bus.RVALID && bus.RREADY;
        if (ARESETn) begin
            seen_rst = 1'b1;
            exp_rd   = '0;
            exp_err  = '0;
        end else if (cur_rhs) begin
            if (sb_q.size() == 0) begin
                fail_now("unexpected_r_beat");
            end else begin
                e = sb_q.pop_front();
                check("sb_rdata", bus.RDATA, e.data);
                check("sb_rresp", 32'(bus.RRESP), 32'(e.resp));
                exp_rd = exp_rd + 16'd1;
                if (e.resp == 2'b10) exp_err = exp_err + 16'd1;
            end
        end
        prev2_rst   = prev_rst;
        prev_rst    = ARESETn;
        prev_arhs   = cur_arhs;
        prev_rhs    = cur_rhs;
        prev_rvalid = bus.RVALID;
        prev_rready = bus.RREADY;
        prev_rdata  = bus.RDATA;
        prev_rresp  = bus.RRESP;
    end

    // Random local writes during the random phase.
    always @(posedge ACLK) begin
        #1;
        if (rnd_en) begin
            reg_we    = ($urandom_range(0, 3) == 0);
            reg_widx  = 4'($urandom_range(0, 15));
            reg_wdata = $urandom;
        end
    end

    task automatic do_write(input logic [3:0] idx, input logic [31:0] data);
        reg_we    = 1'b1;
        reg_widx  = idx;
        reg_wdata = data;
        @(posedge ACLK); #1;
        reg_we    = 1'b0;
    endtask

    // Issues one read; optionally stalls RREADY, checks data directly and
    // performs a local write on the same edge as the AR handshake.
    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int stall,
                           input bit chk, input logic [31:0] req_d, input logic [1:0] req_r,
                           input bit wr, input logic [3:0] widx, input logic [31:0] wdata);
        bit done;
        bus.ARVALID = 1'b1;
        bus.ARADDR  = addr;
        bus.ARPROT  = prot;
        bus.RREADY  = (stall == 0);
        if (wr) begin
            reg_we    = 1'b1;
            reg_widx  = widx;
            reg_wdata = wdata;
        end
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge ACLK);
            if (bus.ARREADY) done = 1'b1;
            @(posedge ACLK); #1;
        end
        bus.ARVALID = 1'b0;
        if (wr) reg_we = 1'b0;
        if (!done) begin
            fail_now("ar_handshake");
            return;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge ACLK);
            check("arready_during_stall", 32'(bus.ARREADY), 32'h0);
            @(posedge ACLK); #1;
        end
        bus.RREADY = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge ACLK);
            if (bus.RVALID) begin
                done = 1'b1;
                if (chk) begin
                    check("direct_rdata", bus.RDATA, req_d);
                    check("direct_rresp", 32'(bus.RRESP), 32'(req_r));
                end
            end
            @(posedge ACLK); #1;
        end
        bus.RREADY = 1'b0;
        if (!done) fail_now("r_handshake");
    endtask

    initial begin
        bit done;
        ARESETn     = 1'b1;
        reg_we      = 1'b0;
        reg_widx    = '0;
        reg_wdata   = '0;
        bus.ARVALID = 1'b0;
        bus.ARADDR  = '0;
        bus.ARPROT  = '0;
        bus.RREADY  = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b0;
        @(posedge ACLK); #1;

        // Basic OKAY read and ignored low address bits
        do_write(4'd3, 32'hCAFE_0003);
        do_read(32'h0C, 3'b000, 0, 1'b1, 32'hCAFE_0003, RESP_OKAY, 1'b0, 4'd0, 32'h0);
        @(negedge ACLK);
        check("rd_count_first", 32'(rd_count), 32'd1);
        @(posedge ACLK); #1;
        do_read(32'h0F, 3'b000, 0, 1'b1, 32'hCAFE_0003, RESP_OKAY, 1'b0, 4'd0, 32'h0);

        // Out of range and privilege
        do_read(32'h40, 3'b000, 0, 1'b1, 32'h0, RESP_SLVERR, 1'b0, 4'd0, 32'h0);
        @(negedge ACLK);
        check("err_count_first", 32'(err_count), 32'd1);
        @(posedge ACLK); #1;
        do_write(4'd12, 32'h1200_00CC);
        do_read(32'h30, 3'b000, 0, 1'b1, 32'h0, RESP_SLVERR, 1'b0, 4'd0, 32'h0);
        do_read(32'h30, 3'b001, 0, 1'b1, 32'h1200_00CC, RESP_OKAY, 1'b0, 4'd0, 32'h0);
        do_read(32'h3C, 3'b110, 0, 1'b1, 32'h0, RESP_SLVERR, 1'b0, 4'd0, 32'h0);

        // RREADY stall
        do_read(32'h0C, 3'b000, 5, 1'b1, 32'hCAFE_0003, RESP_OKAY, 1'b0, 4'd0, 32'h0);

        // Same-edge local write returns the old value
        do_write(4'd2, 32'h0000_1111);
        do_read(32'h08, 3'b000, 0, 1'b1, 32'h0000_1111, RESP_OKAY, 1'b1, 4'd2, 32'h0000_2222);
        do_read(32'h08, 3'b000, 0, 1'b1, 32'h0000_2222, RESP_OKAY, 1'b0, 4'd0, 32'h0);

        // Reset while RVALID is high
        bus.ARVALID = 1'b1;
        bus.ARADDR  = 32'h0C;
        bus.ARPROT  = 3'b000;
        bus.RREADY  = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge ACLK);
            if (bus.ARREADY) done = 1'b1;
            @(posedge ACLK); #1;
        end
        bus.ARVALID = 1'b0;
        if (!done) fail_now("ar_handshake_before_reset");
        @(negedge ACLK);
        check("rvalid_before_reset", 32'(bus.RVALID), 32'h1);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        @(negedge ACLK);
        check("rvalid_after_reset", 32'(bus.RVALID), 32'h0);
        check("rd_count_after_reset", 32'(rd_count), 32'h0);
        @(posedge ACLK); #1;
        do_read(32'h0C, 3'b000, 0, 1'b1, 32'h0, RESP_OKAY, 1'b0, 4'd0, 32'h0);

        // Random traffic
        rnd_en = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = ($urandom_range(0, 20) << 2) | 32'($urandom_range(0, 3));
            do_read(a, 3'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b0, 32'h0, 2'b00,
                    1'b0, 4'd0, 32'h0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge ACLK); #1;
            end
        end
        rnd_en = 1'b0;
        reg_we = 1'b0;
        @(posedge ACLK); #1;

        // Counter wrap
        #1;
        force dut.rd_cnt = 16'hFFFF;
        exp_rd = 16'hFFFF;
        #1;
        release dut.rd_cnt;
        @(posedge ACLK); #1;
        do_read(32'h00, 3'b000, 0, 1'b0, 32'h0, 2'b00, 1'b0, 4'd0, 32'h0);
        @(negedge ACLK);
        check("rd_count_wrap", 32'(rd_count), 32'h0);

        repeat (3) @(posedge ACLK);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
